ps2_xt_keyboard: RTL and testbench

- Sits directly downstream of the PS/2 device-side serial interface and consumes its received-byte strobe and data.
- Translates PS/2 scancode set 2 into XT scancode set 1, using the standard IBM 8042 translation.
- Buffers the translated bytes in a FIFO and presents the head byte, with a valid/IRQ1 level, to the XT keyboard port logic (port 60h read, port 61h acknowledge).
- Throttles the keyboard via the serial interface's inhibit input when the buffer nears full.

---
 rtl/ps2_xt_keyboard.sv | 137 +++++++++++++
 tb/tb_ps2_xt_keyboard.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_xt_keyboard.sv
// PS/2 scancode set 2 to XT set 1 translator (8042 style) with a byte FIFO
// feeding the XT keyboard port logic (port 60h data, port 61h acknowledge, IRQ1).
module ps2_xt_keyboard #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic        iClk,
  input  logic        iRstN,
  input  logic        iRx,
  input  logic [7:0]  iRxData,
  output logic        oInhibit,
  output logic        oValid,
  output logic [7:0]  oScan,
  output logic        oIrq,
  input  logic        iAck,
  output logic        oOverflow,
  output logic [AW:0] oCount
);
  localparam logic [AW:0] FULL_C   = DEPTH[AW:0];
  localparam int          THRESH_I = DEPTH - 2;
  localparam logic [AW:0] THRESH_C = THRESH_I[AW:0];

  // Set-2 to set-1 make code; 00 marks a code with no set-1 equivalent.
  function automatic logic [6:0] xlate(input logic [7:0] c);
    logic [6:0] r;
    case (c)
      8'h01: r = 7'h43; 8'h02: r = 7'h41; 8'h03: r = 7'h3f; 8'h04: r = 7'h3d; 8'h05: r = 7'h3b; 8'h06: r = 7'h3c; 8'h07: r = 7'h58;
      8'h08: r = 7'h64; 8'h09: r = 7'h44; 8'h0a: r = 7'h42; 8'h0b: r = 7'h40; 8'h0c: r = 7'h3e; 8'h0d: r = 7'h0f; 8'h0e: r = 7'h29; 8'h0f: r = 7'h59;
      8'h10: r = 7'h65; 8'h11: r = 7'h38; 8'h12: r = 7'h2a; 8'h13: r = 7'h70; 8'h14: r = 7'h1d; 8'h15: r = 7'h10; 8'h16: r = 7'h02; 8'h17: r = 7'h5a;
      8'h18: r = 7'h66; 8'h19: r = 7'h71; 8'h1a: r = 7'h2c; 8'h1b: r = 7'h1f; 8'h1c: r = 7'h1e; 8'h1d: r = 7'h11; 8'h1e: r = 7'h03; 8'h1f: r = 7'h5b;
      8'h20: r = 7'h67; 8'h21: r = 7'h2e; 8'h22: r = 7'h2d; 8'h23: r = 7'h20; 8'h24: r = 7'h12; 8'h25: r = 7'h05; 8'h26: r = 7'h04; 8'h27: r = 7'h5c;
      8'h28: r = 7'h68; 8'h29: r = 7'h39; 8'h2a: r = 7'h2f; 8'h2b: r = 7'h21; 8'h2c: r = 7'h14; 8'h2d: r = 7'h13; 8'h2e: r = 7'h06; 8'h2f: r = 7'h5d;
      8'h30: r = 7'h69; 8'h31: r = 7'h31; 8'h32: r = 7'h30; 8'h33: r = 7'h23; 8'h34: r = 7'h22; 8'h35: r = 7'h15; 8'h36: r = 7'h07; 8'h37: r = 7'h5e;
      8'h38: r = 7'h6a; 8'h39: r = 7'h72; 8'h3a: r = 7'h32; 8'h3b: r = 7'h24; 8'h3c: r = 7'h16; 8'h3d: r = 7'h08; 8'h3e: r = 7'h09; 8'h3f: r = 7'h5f;
      8'h40: r = 7'h6b; 8'h41: r = 7'h33; 8'h42: r = 7'h25; 8'h43: r = 7'h17; 8'h44: r = 7'h18; 8'h45: r = 7'h0b; 8'h46: r = 7'h0a; 8'h47: r = 7'h60;
      8'h48: r = 7'h6c; 8'h49: r = 7'h34; 8'h4a: r = 7'h35; 8'h4b: r = 7'h26; 8'h4c: r = 7'h27; 8'h4d: r = 7'h19; 8'h4e: r = 7'h0c; 8'h4f: r = 7'h61;
      8'h50: r = 7'h6d; 8'h51: r = 7'h73; 8'h52: r = 7'h28; 8'h53: r = 7'h74; 8'h54: r = 7'h1a; 8'h55: r = 7'h0d; 8'h56: r = 7'h62; 8'h57: r = 7'h6e;
      8'h58: r = 7'h3a; 8'h59: r = 7'h36; 8'h5a: r = 7'h1c; 8'h5b: r = 7'h1b; 8'h5c: r = 7'h75; 8'h5d: r = 7'h2b; 8'h5e: r = 7'h63; 8'h5f: r = 7'h76;
      8'h60: r = 7'h55; 8'h61: r = 7'h56; 8'h62: r = 7'h77; 8'h63: r = 7'h78; 8'h64: r = 7'h79; 8'h65: r = 7'h7a; 8'h66: r = 7'h0e; 8'h67: r = 7'h7b;
      8'h68: r = 7'h7c; 8'h69: r = 7'h4f; 8'h6a: r = 7'h7d; 8'h6b: r = 7'h4b; 8'h6c: r = 7'h47; 8'h6d: r = 7'h7e; 8'h6e: r = 7'h7f; 8'h6f: r = 7'h6f;
      8'h70: r = 7'h52; 8'h71: r = 7'h53; 8'h72: r = 7'h50; 8'h73: r = 7'h4c; 8'h74: r = 7'h4d; 8'h75: r = 7'h48; 8'h76: r = 7'h01; 8'h77: r = 7'h45;
      8'h78: r = 7'h57; 8'h79: r = 7'h4e; 8'h7a: r = 7'h51; 8'h7b: r = 7'h4a; 8'h7c: r = 7'h37; 8'h7d: r = 7'h49; 8'h7e: r = 7'h46; 8'h7f: r = 7'h54;
      8'h83: r = 7'h41;
      default: r = 7'h00;
    endcase
    return r;
  endfunction

  logic       brk_q, brk_d, s1_vld_q, s1_vld_d;
  logic [7:0] s1_data_q, s1_data_d;
  logic [6:0] code;

  // Stage 1: decode one received set-2 byte
  always_comb begin
    brk_d     = brk_q;
    s1_vld_d  = 1'b0;
    s1_data_d = iRxData;
    code      = xlate(iRxData);
    if (iRx) begin
      if (iRxData == 8'hF0) begin
        brk_d = 1'b1;
      end else if (iRxData == 8'hE0 || iRxData == 8'hE1) begin
        s1_vld_d = 1'b1;
      end else if (iRxData <= 8'h83) begin
        brk_d     = 1'b0;
        s1_vld_d  = (code != 7'h00);
        s1_data_d = {brk_q, code};
      end else begin
        brk_d    = 1'b0;
        s1_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      brk_q    <= 1'b0;
      s1_vld_q <= 1'b0;
    end else begin
      brk_q    <= brk_d;
      s1_vld_q <= s1_vld_d;
    end
  end

  always_ff @(posedge iClk) s1_data_q <= s1_data_d;

  // Stage 2: FIFO push/pop and registered port-side status
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          valid_q, irq_q, inh_q, ovf_q;
  logic [7:0]    scan_q;
  logic          pop, push_ok;

  // valid_q lags the count by one cycle, so a pop also requires real occupancy.
  assign pop     = iAck && valid_q && (cnt_q != '0);
  assign push_ok = s1_vld_q && ((cnt_q != FULL_C) || pop);

  always_comb begin
    cnt_d = cnt_q;
    if (push_ok && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!push_ok && pop) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      irq_q   <= 1'b0;
      inh_q   <= 1'b0;
      ovf_q   <= 1'b0;
      scan_q  <= 8'h00;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop)     rd_q <= rd_q + 1'b1;
      if (s1_vld_q && !push_ok) ovf_q <= 1'b1;
      cnt_q   <= cnt_d;
      valid_q <= (cnt_q != '0);
      irq_q   <= (cnt_q != '0);
      inh_q   <= (cnt_q >= THRESH_C);
      scan_q  <= (cnt_q != '0) ? mem_q[rd_q] : 8'h00;
    end
  end

  always_ff @(posedge iClk) begin
    if (push_ok) mem_q[wr_q] <= s1_data_q;
  end

  assign oInhibit  = inh_q;
  assign oValid    = valid_q;
  assign oScan     = scan_q;
  assign oIrq      = irq_q;
  assign oOverflow = ovf_q;
  assign oCount    = cnt_q;
endmodule

// File: tb/tb_ps2_xt_keyboard.sv
// Directed self-checking bench for ps2_xt_keyboard (DEPTH=8).
`timescale 1ns/1ps
module tb_ps2_xt_keyboard;
  logic       clk = 1'b0, rst_n = 1'b0, rx = 1'b0, ack = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       inhibit, valid, irq, ovf;
  logic [7:0] scan;
  logic [3:0] count;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ps2_xt_keyboard #(.DEPTH(8), .AW(3)) dut (
    .iClk(clk), .iRstN(rst_n), .iRx(rx), .iRxData(rx_data),
    .oInhibit(inhibit), .oValid(valid), .oScan(scan), .oIrq(irq),
    .iAck(ack), .oOverflow(ovf), .oCount(count)
  );

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1);
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk); rx = 1'b1; rx_data = b;
    @(negedge clk); rx = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic pop();
    @(negedge clk); ack = 1'b1;
    @(negedge clk); ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", valid); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b want 0", irq); end
    checks++; if (scan !== 8'h00) begin errors++; $display("FAIL rst_scan: got %h want 00", scan); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b want 0", ovf); end
    checks++; if (inhibit !== 1'b0) begin errors++; $display("FAIL rst_inhibit: got %b want 0", inhibit); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", count); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_make_break();
    @(negedge clk); rx = 1'b1; rx_data = 8'h1C;
    @(negedge clk); rx = 1'b0;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL lat_n0: got %b want 0", valid); end
    @(negedge clk);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL lat_n1: got %b want 0", valid); end
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL lat_cnt: got %0d want 1", count); end
    @(negedge clk);
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL lat_n2: got %b want 1", valid); end
    checks++; if (scan !== 8'h1E) begin errors++; $display("FAIL mb_make: got %h want 1e", scan); end
    send(8'hF0);
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL mb_f0_noentry: got %0d want 1", count); end
    send(8'h1C);
    checks++; if (count !== 4'd2) begin errors++; $display("FAIL mb_cnt2: got %0d want 2", count); end
    pop();
    checks++; if (scan !== 8'h9E) begin errors++; $display("FAIL mb_break: got %h want 9e", scan); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL mb_irq_hold: got %b want 1", irq); end
    pop();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL mb_valid_end: got %b want 0", valid); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mb_irq_end: got %b want 0", irq); end
  endtask

  task automatic test_extended();
    logic [7:0] in_b [6] = '{8'hE0, 8'h5A, 8'hE0, 8'hF0, 8'h5A, 8'h76};
    logic [7:0] want [5] = '{8'hE0, 8'h1C, 8'hE0, 8'h9C, 8'h01};
    for (int i = 0; i < 6; i++) send(in_b[i]);
    checks++; if (count !== 4'd5) begin errors++; $display("FAIL ext_cnt: got %0d want 5", count); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (scan !== want[i]) begin errors++; $display("FAIL ext_byte%0d: got %h want %h", i, scan, want[i]); end
      pop();
    end
  endtask

  task automatic test_pause();
    logic [7:0] in_b [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    logic [7:0] want [6] = '{8'hE1, 8'h1D, 8'h45, 8'hE1, 8'h9D, 8'hC5};
    for (int i = 0; i < 8; i++) send(in_b[i]);
    checks++; if (count !== 4'd6) begin errors++; $display("FAIL pause_cnt: got %0d want 6", count); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (scan !== want[i]) begin errors++; $display("FAIL pause_byte%0d: got %h want %h", i, scan, want[i]); end
      pop();
    end
    // Unmapped 00 after F0 is dropped but still clears the break flag.
    send(8'hF0); send(8'h00); send(8'h83);
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL unmap_cnt: got %0d want 1", count); end
    checks++; if (scan !== 8'h41) begin errors++; $display("FAIL unmap_83: got %h want 41", scan); end
    pop();
    send(8'hAA); send(8'hFA);
    checks++; if (scan !== 8'hAA) begin errors++; $display("FAIL pass_aa: got %h want aa", scan); end
    pop();
    checks++; if (scan !== 8'hFA) begin errors++; $display("FAIL pass_fa: got %h want fa", scan); end
    pop();
  endtask

  task automatic test_back_to_back();
    @(negedge clk); rx = 1'b1; rx_data = 8'h1C;
    @(negedge clk); rx_data = 8'hF0;
    @(negedge clk); rx_data = 8'h1C;
    @(negedge clk); rx = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (count !== 4'd2) begin errors++; $display("FAIL b2b_cnt: got %0d want 2", count); end
    checks++; if (scan !== 8'h1E) begin errors++; $display("FAIL b2b_first: got %h want 1e", scan); end
    pop();
    checks++; if (scan !== 8'h9E) begin errors++; $display("FAIL b2b_second: got %h want 9e", scan); end
    pop();
  endtask

  task automatic test_fill_overflow();
    logic [7:0] in_b [9] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    for (int i = 0; i < 5; i++) send(in_b[i]);
    checks++; if (inhibit !== 1'b0) begin errors++; $display("FAIL inh_at5: got %b want 0", inhibit); end
    send(in_b[5]);
    checks++; if (count !== 4'd6) begin errors++; $display("FAIL fill_cnt6: got %0d want 6", count); end
    checks++; if (inhibit !== 1'b1) begin errors++; $display("FAIL inh_at6: got %b want 1", inhibit); end
    send(in_b[6]); send(in_b[7]);
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_at8: got %b want 0", ovf); end
    send(in_b[8]);
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL fill_cnt8: got %0d want 8", count); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", ovf); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (scan !== 8'(i + 2)) begin errors++; $display("FAIL fill_byte%0d: got %h want %h", i, scan, 8'(i + 2)); end
      pop();
    end
    checks++; if (valid !== 1'b0 || irq !== 1'b0) begin errors++; $display("FAIL fill_empty: got valid=%b irq=%b want 0 0", valid, irq); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
  endtask

  task automatic test_reset_mid();
    send(8'h1C); send(8'hF0);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    checks++; if (valid !== 1'b0 || irq !== 1'b0) begin errors++; $display("FAIL midrst_valid: got valid=%b irq=%b want 0 0", valid, irq); end
    checks++; if (scan !== 8'h00 || count !== 4'd0) begin errors++; $display("FAIL midrst_scan: got scan=%h cnt=%0d want 00 0", scan, count); end
    checks++; if (ovf !== 1'b0 || inhibit !== 1'b0) begin errors++; $display("FAIL midrst_flags: got ovf=%b inh=%b want 0 0", ovf, inhibit); end
    rst_n = 1'b1;
    send(8'h29);
    checks++; if (scan !== 8'h39) begin errors++; $display("FAIL midrst_brk: got %h want 39", scan); end
    pop();
  endtask

  task automatic test_simul();
    send(8'h16); send(8'h1E); send(8'h26);
    checks++; if (scan !== 8'h02 || count !== 4'd3) begin errors++; $display("FAIL sim_pre: got scan=%h cnt=%0d want 02 3", scan, count); end
    @(negedge clk); rx = 1'b1; rx_data = 8'h25;
    @(negedge clk); rx = 1'b0; ack = 1'b1;
    @(negedge clk); ack = 1'b0;
    @(negedge clk);
    checks++; if (count !== 4'd3) begin errors++; $display("FAIL sim_cnt: got %0d want 3", count); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (scan !== 8'(i + 3)) begin errors++; $display("FAIL sim_byte%0d: got %h want %h", i, scan, 8'(i + 3)); end
      pop();
    end
    pop();
    checks++; if (count !== 4'd0 || valid !== 1'b0) begin errors++; $display("FAIL ack_empty: got cnt=%0d valid=%b want 0 0", count, valid); end
    // Push arriving while empty with ack held: push wins, pop ignored.
    @(negedge clk); rx = 1'b1; rx_data = 8'h1C;
    @(negedge clk); rx = 1'b0; ack = 1'b1;
    @(negedge clk); ack = 1'b0;
    @(negedge clk);
    checks++; if (count !== 4'd1 || scan !== 8'h1E) begin errors++; $display("FAIL empty_push: got cnt=%0d scan=%h want 1 1e", count, scan); end
    pop();
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_extended();
    test_pause();
    test_back_to_back();
    test_fill_overflow();
    test_reset_mid();
    test_simul();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
